// File: rtl/fmul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add on the significands,
// then one normalise/round cycle. Denormals are flushed to zero.
module fmul_seq #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t             state_q;
   logic [47:0]        ma_q;
   logic [23:0]        mb_q;
   logic [47:0]        prod_q;
   logic [4:0]         cnt_q;
   logic signed [9:0]  exp_q;
   logic               sign_q;
   logic [N-1:0]       out_q;
   logic               out_valid_q;
   logic               in_ready_q;

   logic [7:0]         ea, eb;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic               special_d;
   logic [N-1:0]       spec_d;
   logic signed [9:0]  exp_d;

   logic [23:0]        sig;
   logic               g, r, s, up;
   logic [24:0]        sig_rnd;
   logic [22:0]        frac;
   logic signed [9:0]  e1, e2;
   logic [N-1:0]       norm_d;

   assign ea = a[30:23];
   assign eb = b[30:23];

   always_comb begin
      a_zero    = (ea == 8'h00);
      b_zero    = (eb == 8'h00);
      a_inf     = (ea == 8'hFF) && (a[22:0] == '0);
      b_inf     = (eb == 8'hFF) && (b[22:0] == '0);
      a_nan     = (ea == 8'hFF) && (a[22:0] != '0);
      b_nan     = (eb == 8'hFF) && (b[22:0] != '0);
      special_d = a_zero || b_zero || (ea == 8'hFF) || (eb == 8'hFF);
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
         spec_d = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         spec_d = {a[31] ^ b[31], 8'hFF, 23'd0};
      else
         spec_d = {a[31] ^ b[31], 31'd0};
      exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
   end

   // Product lies in [1,4): pick the 24-bit window, then round-to-nearest-even on g/r/s.
   always_comb begin
      if (prod_q[47]) begin
         sig = prod_q[47:24];
         g   = prod_q[23];
         r   = prod_q[22];
         s   = |prod_q[21:0];
         e1  = exp_q + 10'sd1;
      end else begin
         sig = prod_q[46:23];
         g   = prod_q[22];
         r   = prod_q[21];
         s   = |prod_q[20:0];
         e1  = exp_q;
      end
      up      = g & (r | s | sig[0]);
      sig_rnd = {1'b0, sig} + {24'd0, up};
      if (sig_rnd[24]) begin
         frac = sig_rnd[23:1];
         e2   = e1 + 10'sd1;
      end else begin
         frac = sig_rnd[22:0];
         e2   = e1;
      end
      if (e2 >= 10'sd255)
         norm_d = {sign_q, 8'hFF, 23'd0};
      else if (e2 <= 10'sd0)
         norm_d = {sign_q, 31'd0};
      else
         norm_d = {sign_q, e2[7:0], frac};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ma_q        <= '0;
         mb_q        <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
               in_ready_q <= 1'b0;
               sign_q     <= a[31] ^ b[31];
               exp_q      <= exp_d;
               ma_q       <= {24'd0, 1'b1, a[22:0]};
               mb_q       <= {1'b1, b[22:0]};
               prod_q     <= '0;
               cnt_q      <= '0;
               if (special_d) begin
                  out_q       <= spec_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q <= MUL;
               end
            end
            MUL: begin
               if (mb_q[0])
                  prod_q <= prod_q + ma_q;
               ma_q  <= ma_q << 1;
               mb_q  <= mb_q >> 1;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd23)
                  state_q <= NORM;
            end
            NORM: begin
               out_q       <= norm_d;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: directed corner cases plus random operands
// compared against an integer-arithmetic reference of the multiply/round rules.
module tb_fmul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;

   int checks = 0;
   int fails  = 0;

   fmul_seq #(.N(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e, sh;
      logic sgn, xz, yz, xi, yi, xn, yn;
      longint unsigned mx, my, p, q, rem, half;
      ex  = int'(x[30:23]);
      ey  = int'(y[30:23]);
      sgn = x[31] ^ y[31];
      xz  = (ex == 0);
      yz  = (ey == 0);
      xi  = (ex == 255) && (x[22:0] == 0);
      yi  = (ey == 255) && (y[22:0] == 0);
      xn  = (ex == 255) && (x[22:0] != 0);
      yn  = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xz && yi) || (xi && yz)) return 32'h7FC0_0000;
      if (xi || yi) return {sgn, 8'hFF, 23'd0};
      if (xz || yz) return {sgn, 31'd0};
      mx   = 64'h80_0000 + 64'(x[22:0]);
      my   = 64'h80_0000 + 64'(y[22:0]);
      p    = mx * my;
      e    = ex + ey - 127;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      e    = e + sh - 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q >= (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'd0};
      if (e <= 0) return {sgn, 31'd0};
      return {sgn, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0]  e;
      logic [22:0] f;
      int c;
      c = int'($urandom_range(0, 11));
      f = 23'($urandom);
      if ($urandom_range(0, 5) == 0) f = '0;
      case (c)
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2, 3:    e = 8'($urandom_range(190, 254));
         4, 5:    e = 8'($urandom_range(1, 64));
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, f};
   endfunction

   // One transaction: hold > 0 keeps out_ready low that many cycles once the result shows.
   task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold, input string tag);
      logic [31:0] expv, held;
      int lat, want_lat;
      expv     = ref_mul(av, bv);
      want_lat = is_special(av, bv) ? 1 : 26;
      @(negedge clk);
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 1;
      while (!out_valid && lat < 100) begin
         in_valid = 1'($urandom);
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         lat++;
      end
      check({tag, ":latency"}, 32'(lat), 32'(want_lat));
      check({tag, ":out"}, out, expv);
      held = out;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         a = $urandom;
         b = $urandom;
         @(negedge clk);
         check({tag, ":hold_out"}, out, held);
         check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, ":handoff_valid"}, 32'(out_valid), 32'd0);
      check({tag, ":handoff_no_accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out", out, 32'd0);
      rst = 1'b0;

      do_op(32'h3FC0_0000, 32'h4000_0000, 0, "basic");
      check("basic_const", out, 32'h4040_0000);
      do_op(32'hC000_0000, 32'h3F00_0000, 0, "sign_norm");
      check("sign_norm_const", out, 32'hBF80_0000);
      do_op(32'h3F80_0001, 32'h3F80_0001, 0, "round");
      check("round_const", out, 32'h3F80_0002);
      do_op(32'h0000_0000, 32'h7F80_0000, 0, "zero_x_inf");
      check("zero_x_inf_const", out, 32'h7FC0_0000);
      do_op(32'h7F00_0000, 32'h7F00_0000, 0, "overflow");
      check("overflow_const", out, 32'h7F80_0000);
      do_op(32'h0080_0000, 32'h0080_0000, 0, "underflow");
      do_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, 0, "round_carry");
      do_op(32'hFF80_0000, 32'h3F80_0000, 0, "neg_inf");
      do_op(32'h7FC1_2345, 32'h3F80_0000, 0, "nan_in");
      do_op(32'h4049_0FDB, 32'hC02D_F854, 5, "backpressure");

      // Abort a multiply partway through MUL, then confirm the block is clean afterwards.
      @(negedge clk);
      a        = 32'h4049_0FDB;
      b        = 32'h4049_0FDB;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      check("midreset_out", out, 32'd0);
      do_op(32'h3FC0_0000, 32'h4000_0000, 0, "after_reset");
      check("after_reset_const", out, 32'h4040_0000);

      for (int n = 0; n < 40; n++) begin
         ra = rnd_op();
         rb = rnd_op();
         do_op(ra, rb, (n % 8 == 7) ? 2 : 0, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/fmul_seq.md
FMUL_SEQ -- requirements
Module: fmul_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width; only 32 (1 sign, 8 exponent, 23 mantissa bits) is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a/b are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, N bits: multiplicand, IEEE-754 single.
REQ-007 SHALL have port b, input, N bits: multiplier, IEEE-754 single.
REQ-008 SHALL have port out_valid, output, 1 bit: result on out is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out, output, N bits: product, IEEE-754 single.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, NORM, DONE; reset state IDLE.
REQ-012 SHALL assert in_ready only in IDLE; accept operands when in_valid && in_ready, registering a and b.
REQ-013 SHALL go IDLE->DONE on acceptance when either operand is special (exponent 0x00 or 0xFF); otherwise IDLE->MUL.
REQ-014 SHALL in MUL perform one shift-add step per cycle on 24-bit significands (hidden 1 prepended) into a 48-bit product, 24 cycles, then ->NORM.
REQ-015 SHALL compute exponent as ea+eb-127 in a 10-bit signed intermediate, sign = sa XOR sb.
REQ-016 SHALL in NORM: if product bit 47 set, shift right 1 and increment exponent; round to nearest even using guard, round, sticky; on rounding carry-out renormalise and increment exponent; ->DONE.
REQ-017 SHALL, after NORM, saturate final exponent >=255 to infinity (exp 0xFF, mantissa 0) and final exponent <=0 to signed zero (flush, no denormals).
REQ-018 SHALL treat exponent 0x00 as zero (denormals flushed); NaN input or zero*infinity -> 0x7FC00000; infinity*nonzero -> signed infinity; zero*finite -> signed zero.
REQ-019 SHALL assert out_valid only in DONE; out and out_valid held stable until out_valid && out_ready, then ->IDLE.
REQ-020 SHALL give latency: normal operands, out_valid first high 26 cycles after the acceptance edge; special operands, 1 cycle after.
REQ-021 SHALL ignore in_valid and a/b changes while not in IDLE; no operand queueing.
REQ-022 SHALL not return to IDLE and accept in the same cycle as result handoff; next acceptance earliest the cycle after handoff.

Reset
REQ-023 SHALL on rst high at any clock edge, including mid-MUL/NORM/DONE, force IDLE, out_valid=0, in_ready=1 next cycle, out=0, and discard any in-flight operation.
REQ-024 SHALL clear all datapath registers (product, counter, exponent, sign) to 0 on reset.

Verification
REQ-025 SHALL cover basic: a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> out=0x40400000, out_valid 26 cycles after acceptance.
REQ-026 SHALL cover sign/normalise: a=0xC0000000, b=0x3F000000 -> out=0xBF800000; rounding: a=b=0x3F800001 -> out=0x3F800002.
REQ-027 SHALL cover specials: a=0x00000000, b=0x7F800000 -> 0x7FC00000 one cycle after acceptance; a=0x7F000000, b=0x7F000000 -> 0x7F800000.
REQ-028 SHALL cover backpressure: out_ready low 5 cycles in DONE -> out and out_valid stable, in_ready low, in_valid pulses ignored; handoff on out_ready high.
REQ-029 SHALL cover reset mid-operation: rst high at MUL cycle 10 -> next cycle out_valid=0, in_ready=1, out=0; following operation 0x3FC00000*0x40000000 returns 0x40400000.
